fsk_period_decoder: RTL and testbench

Receive-side front end of the frequency encoder/decoder chip. Takes the raw FSK pulse train from the bidirectional pad input, synchronises it, and measures the clock-cycle period between rising edges. Each period is classified as symbol 0 (low tone), symbol 1 (high tone) or invalid. Runs of CYC_PER_BIT equal symbols become one bit, and bits are assembled LSB-first into bytes. Completed bytes are handed downstream with a one-cycle valid strobe.

---
 rtl/fsk_period_decoder.sv | 175 +++++++++++++++++
 tb/tb_fsk_period_decoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_period_decoder.sv
// fsk_period_decoder
// Receive front end for the FSK link. The raw pulse train is synchronised,
// rising edges are detected, and the clk-cycle spacing between consecutive
// edges is classified as symbol 0 (low tone), symbol 1 (high tone) or
// invalid. CYC_PER_BIT consecutive equal symbols make one bit; bits are
// packed LSB first into bytes.
//
// Ports
//   clk        : rising-edge clock for all logic
//   reset      : synchronous, active-high
//   ena        : receiver enable; low forces IDLE and drops any partial byte
//   pulse_in   : asynchronous FSK pulse train from the pad
//   data_out   : last completed byte, held until the next one completes
//   data_valid : one-cycle strobe in the cycle data_out takes a new byte
//   sym_err    : one-cycle strobe on an invalid period or a mixed-class bit
//   frame_err  : one-cycle strobe on a timeout while a partial byte is pending
//   busy       : high whenever the receiver is not IDLE
//
// Handshake: data_out/data_valid is a push-only interface. There is no ready
// input; the consumer must take data_out in the cycle data_valid is high
// (data_out also stays stable afterwards until the next strobe). At most one
// of data_valid, sym_err and frame_err is high in any cycle.

module fsk_period_decoder #(
  parameter int CNT_W       = 16,
  parameter int F0_MIN      = 90,
  parameter int F0_MAX      = 110,
  parameter int F1_MIN      = 45,
  parameter int F1_MAX      = 55,
  parameter int CYC_PER_BIT = 4,
  parameter int TIMEOUT     = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       pulse_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sym_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] F0_LO     = CNT_W'(F0_MIN);
  localparam logic [CNT_W-1:0] F0_HI     = CNT_W'(F0_MAX);
  localparam logic [CNT_W-1:0] F1_LO     = CNT_W'(F1_MIN);
  localparam logic [CNT_W-1:0] F1_HI     = CNT_W'(F1_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       SYM_LAST  = 4'(CYC_PER_BIT - 1);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             sync_prev;
  logic             edge_evt;
  logic [CNT_W-1:0] period_cnt;
  logic [3:0]       sym_cnt;
  logic [2:0]       bit_cnt;
  logic             cur_sym;
  logic [7:0]       shift_reg;

  logic             is_sym0;
  logic             is_sym1;
  logic             sym_val;
  logic             sym_bad;

  // Two-flop synchroniser plus one edge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= pulse_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_evt = sync2 & ~sync_prev;

  // The counter is loaded with 1 on an edge so that, in the cycle of the
  // next edge, it holds exactly the number of cycles between the two edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (edge_evt) begin
      period_cnt <= CNT_W'(1);
    end else if (period_cnt != CNT_MAX) begin
      period_cnt <= period_cnt + CNT_W'(1);
    end
  end

  assign is_sym0 = (period_cnt >= F0_LO) && (period_cnt <= F0_HI);
  assign is_sym1 = (period_cnt >= F1_LO) && (period_cnt <= F1_HI);
  assign sym_val = is_sym1;
  // A class change only matters once the current bit has started.
  assign sym_bad = !(is_sym0 || is_sym1) ||
                   ((sym_cnt != 4'd0) && (sym_val != cur_sym));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      sym_err    <= 1'b0;
      frame_err  <= 1'b0;
      sym_cnt    <= 4'd0;
      bit_cnt    <= 3'd0;
      cur_sym    <= 1'b0;
      shift_reg  <= 8'h00;
    end else begin
      data_valid <= 1'b0;
      sym_err    <= 1'b0;
      frame_err  <= 1'b0;
      if (!ena) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        sym_cnt <= 4'd0;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            sym_cnt <= 4'd0;
            bit_cnt <= 3'd0;
            // First edge is only the timing reference; nothing is classified.
            if (edge_evt) begin
              state <= ST_ARMED;
              busy  <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (edge_evt) begin
              if (sym_bad) begin
                sym_err <= 1'b1;
                sym_cnt <= 4'd0;
                bit_cnt <= 3'd0;
              end else if (sym_cnt == SYM_LAST) begin
                sym_cnt            <= 4'd0;
                shift_reg[bit_cnt] <= sym_val;
                if (bit_cnt == 3'd7) begin
                  data_out   <= {sym_val, shift_reg[6:0]};
                  data_valid <= 1'b1;
                end
                // Wraps from 7 to 0, restarting the next byte of a stream.
                bit_cnt <= bit_cnt + 3'd1;
              end else begin
                sym_cnt <= sym_cnt + 4'd1;
                cur_sym <= sym_val;
              end
            end else if (period_cnt >= TIMEOUT_C) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= (sym_cnt != 4'd0) || (bit_cnt != 3'd0);
              sym_cnt   <= 4'd0;
              bit_cnt   <= 3'd0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk_period_decoder.sv
// tb_fsk_period_decoder
// Drives pulse trains into fsk_period_decoder and compares every output
// strobe (kind, byte, cycle of appearance) against a reference model that
// works on edge timestamps and a queue of decoded bits.

module tb_fsk_period_decoder;

  localparam int TIMEOUT = 400;
  localparam int CPB     = 4;
  localparam int F0_MIN  = 90;
  localparam int F0_MAX  = 110;
  localparam int F1_MIN  = 45;
  localparam int F1_MAX  = 55;

  localparam int K_VALID = 1;
  localparam int K_SYM   = 2;
  localparam int K_FRAME = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic       pulse_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sym_err;
  logic       frame_err;
  logic       busy;

  fsk_period_decoder #(
    .CNT_W(16), .F0_MIN(F0_MIN), .F0_MAX(F0_MAX), .F1_MIN(F1_MIN),
    .F1_MAX(F1_MAX), .CYC_PER_BIT(CPB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .pulse_in(pulse_in),
    .data_out(data_out), .data_valid(data_valid), .sym_err(sym_err),
    .frame_err(frame_err), .busy(busy)
  );

  // ---------------- clock / reset / cycle stamp ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {kind[1:0], byte[7:0], cycle[31:0]}
  logic [41:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  function automatic void push_exp(int kind, logic [7:0] d, int c);
    exp_q.push_back({2'(kind), d, 32'(c)});
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_armed = 1'b0;
  int         m_last = 0;      // drive cycle of the reference rise
  int         m_cls = 0;       // class of the bit being collected
  int         m_run = 0;       // symbols collected in the current bit
  int         m_bits[$];       // completed bits of the current byte
  logic [7:0] exp_data = 8'h00;

  function automatic int classify(int p);
    if (p >= F1_MIN && p <= F1_MAX) return 1;
    if (p >= F0_MIN && p <= F0_MAX) return 0;
    return -1;
  endfunction

  function automatic void model_clear();
    m_run = 0;
    m_bits.delete();
  endfunction

  // A rise at drive cycle k is seen by the decoder two cycles later and its
  // outputs appear one cycle after that. Silence longer than TIMEOUT since
  // the reference rise ends the frame.
  function automatic void model_advance(int now);
    if (m_armed && now > m_last + TIMEOUT) begin
      if (m_run != 0 || m_bits.size() != 0) push_exp(K_FRAME, 8'h00, m_last + TIMEOUT + 3);
      m_armed = 1'b0;
      model_clear();
    end
  endfunction

  function automatic void model_rise(int k);
    int p;
    int c;
    logic [7:0] b;
    model_advance(k);
    if (!m_armed) begin
      m_armed = 1'b1;
      m_last  = k;
      model_clear();
      return;
    end
    p = k - m_last;
    m_last = k;
    c = classify(p);
    if (c < 0 || (m_run > 0 && c != m_cls)) begin
      push_exp(K_SYM, 8'h00, k + 3);
      model_clear();
    end else begin
      m_cls = c;
      m_run++;
      if (m_run == CPB) begin
        m_bits.push_back(c);
        m_run = 0;
        if (m_bits.size() == 8) begin
          b = 8'h00;
          for (int i = 0; i < 8; i++) b = b | (8'(m_bits[i]) << i);
          exp_data = b;
          push_exp(K_VALID, b, k + 3);
          m_bits.delete();
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  int last_rise = 0;

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_advance(cyc);
    end
  endtask

  task automatic rise();
    int hw;
    hw = $urandom_range(1, 2);
    pulse_in  = 1'b1;
    last_rise = cyc;
    model_rise(cyc);
    tick(hw);
    pulse_in = 1'b0;
  endtask

  // Next rise lands exactly p cycles after the previous one.
  task automatic sym(int p);
    while (cyc < last_rise + p) tick(1);
    rise();
  endtask

  // mode 0: fixed 100/50; mode 1: window edges; mode 2: random in-window.
  function automatic int pick(int mode, logic b, int j);
    if (mode == 0) return b ? 50 : 100;
    if (mode == 1) return b ? (j[0] ? F1_MAX : F1_MIN) : (j[0] ? F0_MAX : F0_MIN);
    return b ? int'($urandom_range(F1_MIN, F1_MAX)) : int'($urandom_range(F0_MIN, F0_MAX));
  endfunction

  task automatic send_bits(logic [7:0] v, int nbits, int mode, int err_pct);
    int p;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < CPB; j++) begin
        p = pick(mode, v[i], j);
        if (err_pct > 0 && int'($urandom_range(0, 99)) < err_pct) p = $urandom_range(3, 200);
        sym(p);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0]  k;
    logic [41:0] act;
    logic [41:0] ex;
    if (mon_en && (data_valid || sym_err || frame_err)) begin
      checks++;
      if (int'(data_valid) + int'(sym_err) + int'(frame_err) > 1) k = 2'd0;
      else if (data_valid) k = 2'(K_VALID);
      else if (sym_err) k = 2'(K_SYM);
      else k = 2'(K_FRAME);
      act = {k, (data_valid ? data_out : 8'h00), 32'(cyc)};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got kind=%0d data=%02h at cycle %0d, expected none",
                 act[41:40], act[39:32], act[31:0]);
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          errors++;
          $display("FAIL strobe: got kind=%0d data=%02h cycle=%0d expected kind=%0d data=%02h cycle=%0d",
                   act[41:40], act[39:32], act[31:0], ex[41:40], ex[39:32], ex[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int bad_p[5] = '{89, 111, 44, 56, 70};

  initial begin
    reset = 1'b1;
    tick(3);
    mon_en = 1'b1;
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_data_valid", 32'(data_valid), 32'h0);
    check("reset_sym_err", 32'(sym_err), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(2);

    // Basic byte with nominal tones.
    rise();
    send_bits(8'hA5, 8, 0, 0);
    tick(5);
    check("byte_a5", 32'(data_out), 32'hA5);
    check("busy_streaming", 32'(busy), 32'h1);

    // Continuous stream: byte from window-edge periods.
    send_bits(8'h5A, 8, 1, 0);
    tick(5);
    check("byte_5a_edges", 32'(data_out), 32'h5A);

    // Out-of-window periods mid-byte, then a clean byte.
    for (int i = 0; i < 5; i++) begin
      send_bits(8'h00, 1, 0, 0);
      sym(bad_p[i]);
    end
    send_bits(8'h3C, 8, 2, 0);
    tick(5);
    check("byte_3c_after_errs", 32'(data_out), 32'h3C);

    // Mixed-class bit, then silence with a symbol pending.
    sym(100);
    sym(100);
    sym(50);
    sym(50);
    tick(450);
    check("busy_after_mixed_timeout", 32'(busy), 32'h0);

    // Three bits then silence.
    rise();
    send_bits(8'h05, 3, 2, 0);
    tick(450);
    check("busy_after_timeout", 32'(busy), 32'h0);

    // Complete byte then silence: timeout without frame error.
    rise();
    send_bits(8'hC3, 8, 2, 0);
    tick(5);
    check("byte_c3", 32'(data_out), 32'hC3);
    tick(450);
    check("busy_after_clean_stop", 32'(busy), 32'h0);

    // Reset in the middle of a byte.
    rise();
    send_bits(8'h1F, 5, 2, 0);
    tick(20);
    reset = 1'b1;
    tick(1);
    check("midreset_data_out", 32'(data_out), 32'h00);
    check("midreset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    m_armed = 1'b0;
    model_clear();
    exp_data = 8'h00;
    tick(2);
    rise();
    send_bits(8'hFF, 8, 2, 0);
    tick(5);
    check("byte_ff", 32'(data_out), 32'hFF);

    // Enable dropped mid-byte.
    rise();
    send_bits(8'h06, 3, 2, 0);
    tick(20);
    ena = 1'b0;
    m_armed = 1'b0;
    model_clear();
    tick(3);
    check("ena_low_busy", 32'(busy), 32'h0);
    check("ena_low_data_kept", 32'(data_out), 32'hFF);
    ena = 1'b1;
    tick(2);
    rise();
    send_bits(8'h81, 8, 2, 0);
    tick(5);
    check("byte_81", 32'(data_out), 32'h81);

    // Random bytes with occasional random periods.
    rise();
    repeat (5) send_bits(8'($urandom), 8, 2, 6);
    tick(450);
    check("busy_after_random", 32'(busy), 32'h0);
    check("random_last_byte", 32'(data_out), 32'(exp_data));

    tick(5);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
